// File: rtl/vel_sweep_ctrl.sv
// Velocity-cache front end: sweeps particle IDs 0..N-1 through the cache read port,
// streams (id, velocity) downstream over valid/ready and registers velocity updates
// into the cache write port. Define VEL_RAW_FWD_EN to forward in-flight writes into reads.
module vel_sweep_ctrl #(
  parameter int RD_LAT             = 2,
  parameter int FIFO_DEPTH         = 4,
  parameter int PARTICLE_ID_WIDTH  = 8,
  parameter int FLOAT_STRUCT_WIDTH = 32
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic [PARTICLE_ID_WIDTH-1:0]  num_particles,
  output logic                          busy,
  output logic                          done,
  output logic [PARTICLE_ID_WIDTH-1:0]  rd_addr,
  input  logic [FLOAT_STRUCT_WIDTH-1:0] cache_vel,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [PARTICLE_ID_WIDTH-1:0]  out_id,
  output logic [FLOAT_STRUCT_WIDTH-1:0] out_vel,
  input  logic                          upd_valid,
  input  logic [PARTICLE_ID_WIDTH-1:0]  upd_id,
  input  logic [FLOAT_STRUCT_WIDTH-1:0] upd_vel,
  output logic                          wr_en,
  output logic [PARTICLE_ID_WIDTH-1:0]  wr_addr,
  output logic [FLOAT_STRUCT_WIDTH-1:0] vel_in
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int LAT_W = $clog2(RD_LAT + 1);

  typedef enum logic [1:0] {IDLE, SWEEP, DRAIN, DONE} state_t;

  typedef struct packed {
    logic [PARTICLE_ID_WIDTH-1:0]  id;
    logic [FLOAT_STRUCT_WIDTH-1:0] vel;
  } entry_t;

  state_t                       state;
  logic [PARTICLE_ID_WIDTH-1:0] n_reg;
  logic [PARTICLE_ID_WIDTH-1:0] next_id;

  logic [RD_LAT-1:0]            pipe_valid;
  logic [PARTICLE_ID_WIDTH-1:0] pipe_id [RD_LAT];

  entry_t                       fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]             wr_ptr;
  logic [PTR_W-1:0]             rd_ptr;
  logic [CNT_W-1:0]             fifo_count;

  logic                          push;
  logic                          pop;
  logic                          issue;
  logic [LAT_W-1:0]              in_flight;
  int                            outstanding;
  logic [FLOAT_STRUCT_WIDTH-1:0] ret_vel;
  entry_t                        head;

  assign push      = pipe_valid[RD_LAT-1];
  assign out_valid = (fifo_count != '0);
  assign pop       = out_valid & out_ready;
  assign head      = fifo_mem[rd_ptr];
  assign out_id    = out_valid ? head.id  : '0;
  assign out_vel   = out_valid ? head.vel : '0;

  // Credits: reads in flight plus buffered entries never exceed the FIFO depth,
  // counting the slot freed by a pop in this same cycle.
  // NOTE: every variable written in always_comb gets a default first, or a latch is inferred.
  always_comb begin
    in_flight = '0;
    for (int i = 0; i < RD_LAT; i++) begin
      in_flight = in_flight + LAT_W'(pipe_valid[i]);
    end
    outstanding = int'(in_flight) + int'(fifo_count) - int'(pop);
    issue       = (state == SWEEP) && (outstanding < FIFO_DEPTH);
  end

`ifdef VEL_RAW_FWD_EN
  logic [RD_LAT-1:0]             pipe_hit;
  logic [FLOAT_STRUCT_WIDTH-1:0] pipe_fwd [RD_LAT];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe_hit <= '0;
    end else begin
      pipe_hit[0] <= 1'b0;
      for (int i = 1; i < RD_LAT; i++) begin
        pipe_hit[i] <= pipe_hit[i-1] |
                       (wr_en && pipe_valid[i-1] && (wr_addr == pipe_id[i-1]));
      end
    end
  end

  // The newest write seen while a read is in flight wins over the cache result.
  always_ff @(posedge clk) begin
    pipe_fwd[0] <= vel_in;
    for (int i = 1; i < RD_LAT; i++) begin
      if (wr_en && pipe_valid[i-1] && (wr_addr == pipe_id[i-1])) begin
        pipe_fwd[i] <= vel_in;
      end else begin
        pipe_fwd[i] <= pipe_fwd[i-1];
      end
    end
  end

  always_comb begin
    ret_vel = cache_vel;
    if (wr_en && (wr_addr == pipe_id[RD_LAT-1])) begin
      ret_vel = vel_in;
    end else if (pipe_hit[RD_LAT-1]) begin
      ret_vel = pipe_fwd[RD_LAT-1];
    end
  end
`else
  assign ret_vel = cache_vel;
`endif

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe_valid <= '0;
    end else begin
      pipe_valid[0] <= issue;
      for (int i = 1; i < RD_LAT; i++) begin
        pipe_valid[i] <= pipe_valid[i-1];
      end
    end
  end

  // NOTE: ID payloads and FIFO storage carry no reset; their valid bits and counters do.
  always_ff @(posedge clk) begin
    pipe_id[0] <= next_id;
    for (int i = 1; i < RD_LAT; i++) begin
      pipe_id[i] <= pipe_id[i-1];
    end
    if (push) begin
      fifo_mem[wr_ptr] <= '{id: pipe_id[RD_LAT-1], vel: ret_vel};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      n_reg   <= '0;
      next_id <= '0;
      rd_addr <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            n_reg   <= num_particles;
            next_id <= '0;
            busy    <= 1'b1;
            if (num_particles == '0) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state <= SWEEP;
            end
          end
        end
        SWEEP: begin
          if (issue) begin
            rd_addr <= next_id;
            next_id <= next_id + 1'b1;
            if (next_id == n_reg - 1'b1) state <= DRAIN;
          end
        end
        DRAIN: begin
          // Finish once nothing is in flight and the last buffered entry leaves now.
          if ((in_flight == '0) && (fifo_count == CNT_W'(pop))) begin
            state <= DONE;
            done  <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_en   <= 1'b0;
      wr_addr <= '0;
      vel_in  <= '0;
    end else begin
      wr_en <= upd_valid;
      if (upd_valid) begin
        wr_addr <= upd_id;
        vel_in  <= upd_vel;
      end
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && (fifo_count == CNT_W'(FIFO_DEPTH)) && !pop));

endmodule

// File: tb/tb_vel_sweep_ctrl.sv
// Self-checking bench for vel_sweep_ctrl: behavioural cache with RD_LAT latency,
// expected streams built from the sweep rules and a shadow copy of cache contents.
module tb_vel_sweep_ctrl;
  localparam int RD_LAT = 2;
  localparam int FIFO_DEPTH = 4;
  localparam int IDW = 8;
  localparam int VW = 32;

  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, out_ready = 1'b0, upd_valid = 1'b0;
  logic [IDW-1:0] num_particles = '0, upd_id = '0;
  logic [VW-1:0]  upd_vel = '0;
  logic busy, done, out_valid, wr_en;
  logic [IDW-1:0] rd_addr, out_id, wr_addr;
  logic [VW-1:0]  cache_vel, out_vel, vel_in;

  always #5 clk = ~clk;

  vel_sweep_ctrl #(.RD_LAT(RD_LAT), .FIFO_DEPTH(FIFO_DEPTH),
                   .PARTICLE_ID_WIDTH(IDW), .FLOAT_STRUCT_WIDTH(VW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .num_particles(num_particles),
    .busy(busy), .done(done), .rd_addr(rd_addr), .cache_vel(cache_vel),
    .out_valid(out_valid), .out_ready(out_ready), .out_id(out_id), .out_vel(out_vel),
    .upd_valid(upd_valid), .upd_id(upd_id), .upd_vel(upd_vel),
    .wr_en(wr_en), .wr_addr(wr_addr), .vel_in(vel_in));

  // Cache: data for the address issued at edge k is presented before edge k+RD_LAT.
  logic [VW-1:0]  cache_mem [256];
  logic [IDW-1:0] addr_hist [RD_LAT-1];
  always @(posedge clk) begin
    addr_hist[0] <= rd_addr;
    for (int i = 1; i < RD_LAT - 1; i++) addr_hist[i] <= addr_hist[i-1];
    if (wr_en) cache_mem[wr_addr] <= vel_in;
  end
  assign cache_vel = cache_mem[addr_hist[RD_LAT-2]];

  logic [VW-1:0] ref_vel [256];
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [IDW-1:0] got_id[$];
  logic [VW-1:0]  got_vel[$];
  int got_cyc[$];
  int done_cnt, done_cyc, busy_cnt, valid_cnt, hold_err;
  bit prev_stall;
  logic [IDW-1:0] prev_id;
  logic [VW-1:0]  prev_vel;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (out_valid && out_ready) begin
        got_id.push_back(out_id); got_vel.push_back(out_vel); got_cyc.push_back(cyc);
      end
      if (done) begin done_cnt++; done_cyc = cyc; end
      if (busy) busy_cnt++;
      if (out_valid) valid_cnt++;
      if (prev_stall && (!out_valid || out_id !== prev_id || out_vel !== prev_vel)) hold_err++;
      prev_stall = out_valid && !out_ready;
      prev_id = out_id;
      prev_vel = out_vel;
    end
  end

  int checks = 0, failures = 0;

  task automatic clear_mon();
    got_id.delete(); got_vel.delete(); got_cyc.delete();
    done_cnt = 0; done_cyc = -1; busy_cnt = 0; valid_cnt = 0; hold_err = 0;
  endtask

  // Called #1 after an edge; returns #1 after the edge that samples start.
  task automatic start_sweep(input int n, output int c0);
    start = 1'b1; num_particles = IDW'(n);
    @(posedge clk); #1;
    c0 = cyc; start = 1'b0; num_particles = IDW'($urandom);
  endtask

  task automatic wait_idle(input int budget, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < budget; k++) begin
      @(posedge clk); #1;
      if (!busy) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; upd_valid = 1'b1; upd_id = 8'd5; upd_vel = 32'hDEAD_BEEF; start = 1'b1;
    repeat (3) @(posedge clk); #1;
    checks++; if ({busy, done, out_valid, wr_en} !== 4'b0) begin failures++;
      $display("FAIL reset_flags: got %b want 0000", {busy, done, out_valid, wr_en}); end
    checks++; if (rd_addr !== '0) begin failures++; $display("FAIL reset_rd_addr: got %0h want 0", rd_addr); end
    checks++; if (out_id !== '0) begin failures++; $display("FAIL reset_out_id: got %0h want 0", out_id); end
    checks++; if (out_vel !== '0) begin failures++; $display("FAIL reset_out_vel: got %0h want 0", out_vel); end
    checks++; if (wr_addr !== '0) begin failures++; $display("FAIL reset_wr_addr: got %0h want 0", wr_addr); end
    checks++; if (vel_in !== '0) begin failures++; $display("FAIL reset_vel_in: got %0h want 0", vel_in); end
    upd_valid = 1'b0; start = 1'b0; rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_sweep5();
    int c0; bit ok;
    clear_mon(); out_ready = 1'b1;
    start_sweep(5, c0);
    wait_idle(100, ok);
    checks++; if (!ok) begin failures++; $display("FAIL sweep5_timeout: busy stuck, want idle"); end
    checks++; if (got_id.size() != 5) begin failures++; $display("FAIL sweep5_count: got %0d want 5", got_id.size()); end
    for (int i = 0; i < got_id.size() && i < 5; i++) begin
      checks++; if (got_id[i] !== IDW'(i)) begin failures++; $display("FAIL sweep5_id[%0d]: got %0d want %0d", i, got_id[i], i); end
      checks++; if (got_vel[i] !== ref_vel[i]) begin failures++; $display("FAIL sweep5_vel[%0d]: got %0h want %0h", i, got_vel[i], ref_vel[i]); end
      checks++; if (got_cyc[i] != c0 + RD_LAT + 1 + i) begin failures++;
        $display("FAIL sweep5_cycle[%0d]: got %0d want %0d", i, got_cyc[i] - c0, RD_LAT + 1 + i); end
    end
    checks++; if (done_cnt != 1) begin failures++; $display("FAIL sweep5_done_cnt: got %0d want 1", done_cnt); end
    checks++; if (done_cyc != c0 + RD_LAT + 1 + 5) begin failures++;
      $display("FAIL sweep5_done_cycle: got %0d want %0d", done_cyc - c0, RD_LAT + 6); end
    checks++; if (busy_cnt != RD_LAT + 7) begin failures++; $display("FAIL sweep5_busy_cycles: got %0d want %0d", busy_cnt, RD_LAT + 7); end
  endtask

  task automatic test_zero();
    int c0;
    clear_mon();
    start_sweep(0, c0);
    repeat (10) @(posedge clk); #1;
    checks++; if (done_cnt != 1) begin failures++; $display("FAIL zero_done_cnt: got %0d want 1", done_cnt); end
    checks++; if (done_cyc != c0) begin failures++; $display("FAIL zero_done_cycle: got %0d want 0", done_cyc - c0); end
    checks++; if (busy_cnt != 1) begin failures++; $display("FAIL zero_busy_cycles: got %0d want 1", busy_cnt); end
    checks++; if (valid_cnt != 0) begin failures++; $display("FAIL zero_out_valid: got %0d want 0", valid_cnt); end
  endtask

  task automatic test_toggle16();
    int c0; bit ok;
    clear_mon(); out_ready = 1'b0;
    start_sweep(16, c0);
    ok = 1'b0;
    for (int k = 0; k < 300; k++) begin
      @(posedge clk); #1;
      out_ready = ~out_ready;
      start = (cyc == c0 + 4);
      if (start) num_particles = 8'd3;
      if (!busy) begin ok = 1'b1; break; end
    end
    start = 1'b0; out_ready = 1'b1;
    checks++; if (!ok) begin failures++; $display("FAIL toggle_timeout: busy stuck, want idle"); end
    checks++; if (got_id.size() != 16) begin failures++; $display("FAIL toggle_count: got %0d want 16", got_id.size()); end
    for (int i = 0; i < got_id.size() && i < 16; i++) begin
      checks++; if (got_id[i] !== IDW'(i)) begin failures++; $display("FAIL toggle_id[%0d]: got %0d want %0d", i, got_id[i], i); end
      checks++; if (got_vel[i] !== ref_vel[i]) begin failures++; $display("FAIL toggle_vel[%0d]: got %0h want %0h", i, got_vel[i], ref_vel[i]); end
    end
    checks++; if (done_cnt != 1) begin failures++; $display("FAIL toggle_done_cnt: got %0d want 1", done_cnt); end
    checks++; if (hold_err != 0) begin failures++; $display("FAIL toggle_stall_hold: got %0d changes want 0", hold_err); end
  endtask

  task automatic test_write_path();
    logic [VW-1:0] x, ed;
    logic [IDW-1:0] ea;
    bit ev;
    x = $urandom;
    upd_valid = 1'b1; upd_id = 8'd7; upd_vel = x;
    @(posedge clk); #1;
    upd_valid = 1'b0; upd_id = IDW'($urandom); upd_vel = $urandom;
    checks++; if (wr_en !== 1'b1) begin failures++; $display("FAIL wr_en_pulse: got %0b want 1", wr_en); end
    checks++; if (wr_addr !== 8'd7) begin failures++; $display("FAIL wr_addr_7: got %0d want 7", wr_addr); end
    checks++; if (vel_in !== x) begin failures++; $display("FAIL vel_in_x: got %0h want %0h", vel_in, x); end
    ref_vel[7] = x;
    @(posedge clk); #1;
    checks++; if (wr_en !== 1'b0) begin failures++; $display("FAIL wr_en_drop: got %0b want 0", wr_en); end
    ev = 1'b0; ea = '0; ed = '0;
    for (int k = 0; k < 30; k++) begin
      @(posedge clk); #1;
      checks++; if (wr_en !== ev) begin failures++; $display("FAIL rnd_wr_en[%0d]: got %0b want %0b", k, wr_en, ev); end
      if (ev) begin
        checks++; if (wr_addr !== ea || vel_in !== ed) begin failures++;
          $display("FAIL rnd_wr_data[%0d]: got %0d/%0h want %0d/%0h", k, wr_addr, vel_in, ea, ed); end
        ref_vel[ea] = ed;
      end
      upd_valid = (k < 29) ? 1'($urandom % 2) : 1'b0;
      upd_id = IDW'($urandom); upd_vel = $urandom;
      ev = upd_valid; ea = upd_id; ed = upd_vel;
    end
    repeat (2) @(posedge clk); #1;
  endtask

  task automatic test_raw();
    int c0; bit ok, seen;
    logic [VW-1:0] w;
    logic [IDW-1:0] prev, want_vel_id;
    logic [VW-1:0] want_vel;
    clear_mon(); out_ready = 1'b1; w = $urandom; seen = 1'b0;
    start_sweep(8, c0);
    prev = rd_addr; ok = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(posedge clk); #1;
      upd_valid = 1'b0;
      if (!seen && rd_addr == 8'd3 && prev != 8'd3) begin
        upd_valid = 1'b1; upd_id = 8'd3; upd_vel = w; seen = 1'b1;
      end
      prev = rd_addr;
      if (!busy) begin ok = 1'b1; break; end
    end
    upd_valid = 1'b0;
    checks++; if (!ok || !seen) begin failures++; $display("FAIL raw_setup: ok=%0b seen=%0b want 1/1", ok, seen); end
    checks++; if (got_id.size() != 8) begin failures++; $display("FAIL raw_count: got %0d want 8", got_id.size()); end
    for (int i = 0; i < got_id.size() && i < 8; i++) begin
      want_vel_id = IDW'(i);
      checks++; if (got_id[i] !== want_vel_id) begin failures++; $display("FAIL raw_id[%0d]: got %0d want %0d", i, got_id[i], i); end
      want_vel = ref_vel[i];
`ifdef VEL_RAW_FWD_EN
      if (i == 3) want_vel = w;
      checks++; if (got_vel[i] !== want_vel) begin failures++; $display("FAIL raw_vel[%0d]: got %0h want %0h", i, got_vel[i], want_vel); end
`else
      if (i != 3) begin
        checks++; if (got_vel[i] !== want_vel) begin failures++; $display("FAIL raw_vel[%0d]: got %0h want %0h", i, got_vel[i], want_vel); end
      end
`endif
    end
    ref_vel[3] = w;
  endtask

  task automatic test_random_sweeps();
    int c0, n; bit ok;
    for (int s = 0; s < 4; s++) begin
      clear_mon(); n = $urandom_range(1, 24);
      start_sweep(n, c0);
      ok = 1'b0;
      for (int k = 0; k < 400; k++) begin
        @(posedge clk); #1;
        out_ready = ($urandom % 4) != 0;
        if (!busy) begin ok = 1'b1; break; end
      end
      checks++; if (!ok) begin failures++; $display("FAIL rnd%0d_timeout: busy stuck, want idle", s); end
      checks++; if (got_id.size() != n) begin failures++; $display("FAIL rnd%0d_count: got %0d want %0d", s, got_id.size(), n); end
      for (int i = 0; i < got_id.size() && i < n; i++) begin
        checks++; if (got_id[i] !== IDW'(i) || got_vel[i] !== ref_vel[i]) begin failures++;
          $display("FAIL rnd%0d_entry[%0d]: got %0d/%0h want %0d/%0h", s, i, got_id[i], got_vel[i], i, ref_vel[i]); end
      end
      checks++; if (done_cnt != 1 || hold_err != 0) begin failures++;
        $display("FAIL rnd%0d_done_hold: got done=%0d holderr=%0d want 1/0", s, done_cnt, hold_err); end
    end
    out_ready = 1'b1;
  endtask

  task automatic test_reset_mid();
    int c0; bit ok, hit;
    logic [IDW-1:0] prev;
    clear_mon(); out_ready = 1'b1;
    start_sweep(10, c0);
    prev = rd_addr; hit = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(posedge clk); #1;
      if (rd_addr == 8'd6 && prev != 8'd6) begin hit = 1'b1; break; end
      prev = rd_addr;
    end
    rst_n = 1'b0; #1;
    checks++; if (!hit) begin failures++; $display("FAIL midrst_reach6: got no issue of ID 6, want one"); end
    checks++; if ({busy, done, out_valid} !== 3'b0) begin failures++;
      $display("FAIL midrst_flags: got %b want 000", {busy, done, out_valid}); end
    checks++; if (rd_addr !== '0 || out_id !== '0 || out_vel !== '0) begin failures++;
      $display("FAIL midrst_data: got %0d/%0d/%0h want 0/0/0", rd_addr, out_id, out_vel); end
    repeat (2) @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++; if (done_cnt != 0) begin failures++; $display("FAIL midrst_no_done: got %0d want 0", done_cnt); end
    clear_mon();
    start_sweep(4, c0);
    wait_idle(100, ok);
    checks++; if (!ok || got_id.size() != 4) begin failures++;
      $display("FAIL resweep_count: got ok=%0b n=%0d want 1/4", ok, got_id.size()); end
    for (int i = 0; i < got_id.size() && i < 4; i++) begin
      checks++; if (got_id[i] !== IDW'(i) || got_vel[i] !== ref_vel[i]) begin failures++;
        $display("FAIL resweep_entry[%0d]: got %0d/%0h want %0d/%0h", i, got_id[i], got_vel[i], i, ref_vel[i]); end
    end
    checks++; if (done_cnt != 1) begin failures++; $display("FAIL resweep_done: got %0d want 1", done_cnt); end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      cache_mem[i] = $urandom;
      ref_vel[i] = cache_mem[i];
    end
    clear_mon();
    test_reset();
    test_sweep5();
    test_zero();
    test_toggle16();
    test_write_path();
    test_raw();
    test_random_sweeps();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
